pipeline_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 41 ++++
 rtl/pipeline_ctrl_if.sv | 47 ++++
 rtl/hazard_unit.sv | 19 +
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline controller: register index type,
// controller state encoding and the bundle of latch-control outputs.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } pctrl_state_t;

    // Raw state codes used inside the controller FSM; they match pctrl_state_t.
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    // One cycle's worth of controller outputs.
    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
        logic halted;
    } pctrl_out_t;

    // Output patterns, bit order as in pctrl_out_t.
    localparam pctrl_out_t OUT_NONE       = pctrl_out_t'(8'b0000_0000);
    localparam pctrl_out_t OUT_FLOW       = pctrl_out_t'(8'b1111_1000);
    localparam pctrl_out_t OUT_BUBBLE     = pctrl_out_t'(8'b0011_1010);
    localparam pctrl_out_t OUT_REDIRECT   = pctrl_out_t'(8'b1111_1110);
    localparam pctrl_out_t OUT_HALT_ENTRY = pctrl_out_t'(8'b0111_1110);
    localparam pctrl_out_t OUT_DRAIN      = pctrl_out_t'(8'b0000_1000);
    localparam pctrl_out_t OUT_HALTED     = pctrl_out_t'(8'b0000_0001);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the datapath (master) and the hazard/sequencing
// controller (slave).
//
// Handshake semantics: ihit and dhit are level "done" strobes sampled every
// cycle. ihit=1 means the fetch for the current PC is available this cycle;
// dhit=1 means the MEM-stage access held by mem_req finishes this cycle. The
// controller never waits on a request of its own; it only gates latch
// enables, so a pipeline stage advances exactly in cycles where its enable is 1.
interface pipeline_ctrl_if;
    import cpu_types_pkg::*;

    // datapath -> controller
    logic     ihit;
    logic     dhit;
    logic     mem_req;
    logic     idex_memread;
    regbits_t idex_rt;
    regbits_t ifid_rs;
    regbits_t ifid_rt;
    logic     ex_redirect;
    logic     halt_in;

    // controller -> datapath
    logic     pc_en;
    logic     en_ifid;
    logic     en_idex;
    logic     en_exmem;
    logic     en_memwb;
    logic     flush_IFID;
    logic     flush_IDEX;
    logic     halted;

    modport master (
        output ihit, dhit, mem_req, idex_memread, idex_rt, ifid_rs, ifid_rt,
               ex_redirect, halt_in,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_IFID,
               flush_IDEX, halted
    );

    modport slave (
        input  ihit, dhit, mem_req, idex_memread, idex_rt, ifid_rs, ifid_rt,
               ex_redirect, halt_in,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_IFID,
               flush_IDEX, halted
    );

endinterface

// File: rtl/hazard_unit.sv
// Load-use hazard detection: the load in ID/EX writes a register that the
// instruction in IF/ID reads. Register 0 never creates a dependency.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     idex_memread,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     loaduse
);

    // Pure combinational compare against both source fields.
    always_comb begin
        loaduse = idex_memread && (idex_rt != 5'd0) &&
                  ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard and sequencing controller for the 5-stage pipeline.
// Drives PC enable and the IF/ID, ID/EX, EX/MEM, MEM/WB enables/flushes.
// States: RUN, MEMWAIT (dcache wait), DRAIN (HALT writeback), HALT.
// Outputs are Mealy and forced to 0 while nRST is low.
// Optional build macro PERF_CNT_EN adds saturating stall_cycles and
// flush_events counters of width CNT_W.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    pipeline_ctrl_if.slave    pif,
    output pctrl_state_t      state_dbg
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
`endif
);

    logic       [1:0] state_q;
    logic       [1:0] state_d;
    logic             freeze;
    logic             loaduse;
    pctrl_out_t       flow_o;
    pctrl_out_t       out_o;

    hazard_unit u_hazard (
        .idex_memread (pif.idex_memread),
        .idex_rt      (pif.idex_rt),
        .ifid_rs      (pif.ifid_rs),
        .ifid_rt      (pif.ifid_rt),
        .loaduse      (loaduse)
    );

    // An outstanding MEM access that has not completed freezes everything.
    always_comb begin
        freeze = pif.mem_req && !pif.dhit;
    end

    // Unfrozen RUN priority: halt, redirect, then front-end hold (load-use
    // or icache miss). A redirect discards whatever the front end was doing,
    // so a concurrent load-use or icache miss does not matter.
    always_comb begin
        flow_o = OUT_FLOW;
        if (pif.halt_in) begin
            flow_o = OUT_HALT_ENTRY;
        end else if (pif.ex_redirect) begin
            flow_o = OUT_REDIRECT;
        end else if (loaduse || !pif.ihit) begin
            flow_o = OUT_BUBBLE;
        end
    end

    // Next-state and Mealy output selection.
    always_comb begin
        state_d = state_q;
        out_o   = OUT_NONE;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_MEMWAIT;
                end else begin
                    out_o = flow_o;
                    if (pif.halt_in) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_MEMWAIT: begin
                // EX inputs were held during the freeze, so the releasing
                // cycle serves any redirect or halt that arrived with it.
                if (pif.dhit) begin
                    out_o   = flow_o;
                    state_d = pif.halt_in ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                out_o   = OUT_DRAIN;
                state_d = ST_HALT;
            end
            ST_HALT: begin
                out_o = OUT_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!nRST) begin
            out_o = OUT_NONE;
        end
    end

    // State register; reset returns to RUN from anywhere.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drive the interface and the debug state view.
    always_comb begin
        pif.pc_en      = out_o.pc_en;
        pif.en_ifid    = out_o.en_ifid;
        pif.en_idex    = out_o.en_idex;
        pif.en_exmem   = out_o.en_exmem;
        pif.en_memwb   = out_o.en_memwb;
        pif.flush_IFID = out_o.flush_ifid;
        pif.flush_IDEX = out_o.flush_idex;
        pif.halted     = out_o.halted;
        state_dbg      = pctrl_state_t'(state_q);
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] flush_d;

    // Saturating counters: stalls counted only in RUN/MEMWAIT with the PC held.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (((state_q == ST_RUN) || (state_q == ST_MEMWAIT)) && !out_o.pc_en &&
            (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (out_o.flush_ifid && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Counter outputs.
    always_comb begin
        stall_cycles = stall_q;
        flush_events = flush_q;
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table-driven RUN vectors, a short
// random RUN section, and hand-written multi-cycle sequences for freeze,
// redirect-under-freeze, halt drain and reset recovery.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    localparam int CNT_W = 16;
    localparam int W     = 10;

    // Expected word: {pc_en, en_ifid, en_idex, en_exmem, en_memwb,
    //                 flush_IFID, flush_IDEX, halted, state[1:0]}
    localparam logic [W-1:0] E_ZERO     = 10'b00000_00_0_00;
    localparam logic [W-1:0] E_ALL1     = 10'b11111_00_0_00;
    localparam logic [W-1:0] E_LU       = 10'b00111_01_0_00;
    localparam logic [W-1:0] E_RD       = 10'b11111_11_0_00;
    localparam logic [W-1:0] E_HALTIN   = 10'b01111_11_0_00;
    localparam logic [W-1:0] E_FRZ_MW   = 10'b00000_00_0_01;
    localparam logic [W-1:0] E_REL_MW   = 10'b11111_00_0_01;
    localparam logic [W-1:0] E_RD_MW    = 10'b11111_11_0_01;
    localparam logic [W-1:0] E_HALT_MW  = 10'b01111_11_0_01;
    localparam logic [W-1:0] E_DRAIN    = 10'b00001_00_0_10;
    localparam logic [W-1:0] E_HALTED   = 10'b00000_00_1_11;

    typedef struct packed {
        logic       ihit;
        logic       dhit;
        logic       mem_req;
        logic       idex_memread;
        logic [4:0] idex_rt;
        logic [4:0] ifid_rs;
        logic [4:0] ifid_rt;
        logic       ex_redirect;
        logic       halt_in;
    } stim_t;

    typedef struct {
        stim_t        s;
        logic [W-1:0] e;
        string        name;
    } vec_t;

    logic         CLK = 1'b0;
    logic         nRST;
    pctrl_state_t state_dbg;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
`endif

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    vec_t         tbl[12];

    pipeline_ctrl_if pif();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pif          (pif),
        .state_dbg    (state_dbg)
`ifdef PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    // Clock.
    always #5 CLK = ~CLK;

    function automatic stim_t mk(input logic ihit, input logic dhit,
                                 input logic mem_req, input logic rd,
                                 input logic [4:0] ex_rt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic redir,
                                 input logic halt);
        stim_t s;
        s.ihit = ihit; s.dhit = dhit; s.mem_req = mem_req; s.idex_memread = rd;
        s.idex_rt = ex_rt; s.ifid_rs = rs; s.ifid_rt = rt;
        s.ex_redirect = redir; s.halt_in = halt;
        return s;
    endfunction

    function automatic logic [W-1:0] observe();
        logic [1:0] st;
        st = state_dbg;
        return {pif.pc_en, pif.en_ifid, pif.en_idex, pif.en_exmem, pif.en_memwb,
                pif.flush_IFID, pif.flush_IDEX, pif.halted, st};
    endfunction

    // Driver.
    task automatic drive(input stim_t s);
        pif.ihit         = s.ihit;
        pif.dhit         = s.dhit;
        pif.mem_req      = s.mem_req;
        pif.idex_memread = s.idex_memread;
        pif.idex_rt      = s.idex_rt;
        pif.ifid_rs      = s.ifid_rs;
        pif.ifid_rt      = s.ifid_rt;
        pif.ex_redirect  = s.ex_redirect;
        pif.halt_in      = s.halt_in;
    endtask

    // Scoreboard: pop the oldest expectation and compare with the DUT.
    task automatic check_out(input string name);
        logic [W-1:0] exp_v;
        logic [W-1:0] got;
        exp_v = exp_q.pop_front();
        got   = observe();
        n_checks++;
        if (got !== exp_v) begin
            $display("FAIL %s: got %b expected %b", name, got, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    // One cycle: drive at the falling edge, check mid low phase.
    task automatic step(input string name, input stim_t s, input logic [W-1:0] e);
        @(negedge CLK);
        drive(s);
        exp_q.push_back(e);
        #2;
        check_out(name);
    endtask

    // Assert reset for one cycle with live inputs; outputs must all be 0.
    task automatic do_reset(input string name);
        @(negedge CLK);
        nRST = 1'b0;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(E_ZERO);
        #2;
        check_out(name);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

`ifdef PERF_CNT_EN
    task automatic check_cnt(input string name, input logic [CNT_W-1:0] got,
                             input logic [CNT_W-1:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
        end else begin
            n_pass++;
        end
    endtask
`endif

    initial begin
        stim_t        s;
        stim_t        idle;
        logic [W-1:0] e;
        logic         lu;

        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        drive(idle);

        tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0), E_ALL1, "idle_flow"};
        tbl[1]  = '{mk(1, 0, 0, 1, 8, 8, 0, 0, 0), E_LU,   "loaduse_rs"};
        tbl[2]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0), E_ALL1, "loaduse_clear"};
        tbl[3]  = '{mk(1, 0, 0, 1, 8, 3, 8, 0, 0), E_LU,   "loaduse_rt"};
        tbl[4]  = '{mk(1, 0, 0, 1, 0, 0, 0, 0, 0), E_ALL1, "r0_no_stall"};
        tbl[5]  = '{mk(1, 0, 0, 0, 8, 8, 8, 0, 0), E_ALL1, "no_memread"};
        tbl[6]  = '{mk(1, 0, 0, 1, 8, 9, 10, 0, 0), E_ALL1, "no_match"};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), E_LU,   "imiss"};
        tbl[8]  = '{mk(0, 0, 0, 1, 8, 8, 0, 1, 0), E_RD,   "redir_over_lu_imiss"};
        tbl[9]  = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 0), E_RD,   "redir"};
        tbl[10] = '{mk(1, 1, 1, 0, 0, 0, 0, 0, 0), E_ALL1, "mem_hit_no_freeze"};
        tbl[11] = '{mk(1, 0, 0, 1, 31, 31, 2, 0, 0), E_LU, "loaduse_r31"};

        do_reset("reset_init");

        // Table-driven RUN vectors.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].name, tbl[i].s, tbl[i].e);
        end

        // Random RUN traffic (dhit held so no freeze, no halt).
        for (int i = 0; i < 24; i++) begin
            s = mk(($urandom_range(0, 3) != 0), 1, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 4) == 0), 0);
            lu = s.idex_memread && (s.idex_rt != 0) &&
                 ((s.idex_rt == s.ifid_rs) || (s.idex_rt == s.ifid_rt));
            if (s.ex_redirect) e = E_RD;
            else if (lu || !s.ihit) e = E_LU;
            else e = E_ALL1;
            step("rand_run", s, e);
        end

        // Freeze for 3 cycles, then release.
        do_reset("reset_b");
        step("frz1", mk(1, 0, 1, 0, 0, 0, 0, 0, 0), E_ZERO);
        step("frz2", mk(1, 0, 1, 0, 0, 0, 0, 0, 0), E_FRZ_MW);
        step("frz3", mk(1, 0, 1, 0, 0, 0, 0, 0, 0), E_FRZ_MW);
        step("frz_release", mk(1, 1, 1, 0, 0, 0, 0, 0, 0), E_REL_MW);
        step("frz_after", idle, E_ALL1);
`ifdef PERF_CNT_EN
        check_cnt("stall_after_freeze", stall_cycles, 16'd3);
        check_cnt("flush_after_freeze", flush_events, 16'd0);
`endif

        // Redirect arriving under a freeze is served on the release cycle.
        do_reset("reset_c");
        step("rd_frz1", mk(1, 0, 1, 0, 0, 0, 0, 1, 0), E_ZERO);
        step("rd_frz2", mk(1, 0, 1, 0, 0, 0, 0, 1, 0), E_FRZ_MW);
        step("rd_release", mk(1, 1, 1, 0, 0, 0, 0, 1, 0), E_RD_MW);
        step("rd_after", idle, E_ALL1);
`ifdef PERF_CNT_EN
        check_cnt("stall_after_rd", stall_cycles, 16'd2);
        check_cnt("flush_after_rd", flush_events, 16'd1);
`endif

        // Halt, drain, halted, then reset out of HALT.
        do_reset("reset_d");
        step("halt_entry", mk(1, 0, 0, 0, 0, 0, 0, 0, 1), E_HALTIN);
        step("drain", idle, E_DRAIN);
        step("halted1", idle, E_HALTED);
        step("halted2", mk(1, 1, 1, 1, 8, 8, 8, 1, 1), E_HALTED);
`ifdef PERF_CNT_EN
        check_cnt("stall_after_halt", stall_cycles, 16'd1);
        check_cnt("flush_after_halt", flush_events, 16'd1);
`endif
        do_reset("reset_mid_halt");
        step("run_after_halt", idle, E_ALL1);

        // Halt coincident with a freeze.
        step("hf_frz", mk(1, 0, 1, 0, 0, 0, 0, 0, 1), E_ZERO);
        step("hf_release", mk(1, 1, 1, 0, 0, 0, 0, 0, 1), E_HALT_MW);
        step("hf_drain", idle, E_DRAIN);
        step("hf_halted", idle, E_HALTED);

        // Reset in the middle of a freeze.
        do_reset("reset_e");
        step("mf_frz1", mk(1, 0, 1, 0, 0, 0, 0, 0, 0), E_ZERO);
        step("mf_frz2", mk(1, 0, 1, 0, 0, 0, 0, 0, 0), E_FRZ_MW);
        do_reset("reset_mid_freeze");
        step("run_after_freeze_reset", idle, E_ALL1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
